// File: rtl/ppu_pkg.sv
// Shared types and arithmetic helpers for the post-processing unit.
package ppu_pkg;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_QUANT = 2'd1,
        S_OUT   = 2'd2
    } ppu_state_e;

    localparam int unsigned PPU_OUT_WIDTH = 8;

    function automatic int out_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int out_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

    localparam int OUT_MAX = out_max(PPU_OUT_WIDTH);
    localparam int OUT_MIN = out_min(PPU_OUT_WIDTH);

    // Signed add clamped to the limits of a w-bit signed value (w <= 63).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        w);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/ppu_requant.sv
// Single-element requantiser: bias add, round-half-up shift, optional ReLU, signed saturation.
module ppu_requant
    import ppu_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned OUT_WIDTH = PPU_OUT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    input  logic signed [ACC_WIDTH-1:0] i_bias,
    input  logic        [4:0]           i_shift,
    input  logic                        i_relu,
    output logic signed [OUT_WIDTH-1:0] o_q,
    output logic                        o_sat
);

    // Two guard bits: one for the bias add, one for the rounding increment.
    localparam int unsigned VW = ACC_WIDTH + 2;
    localparam logic signed [VW-1:0] MAXV = VW'(out_max(OUT_WIDTH));
    localparam logic signed [VW-1:0] MINV = VW'(out_min(OUT_WIDTH));

    logic signed [VW-1:0] w_sum;
    logic signed [VW-1:0] w_rnd;
    logic signed [VW-1:0] w_rl;

    always_comb begin
        w_sum = VW'(i_acc) + VW'(i_bias);
        w_rnd = w_sum;
        if (i_shift != 5'd0) begin
            w_rnd = (w_sum + (VW'(1) <<< (i_shift - 5'd1))) >>> i_shift;
        end
        w_rl  = (i_relu && w_rnd[VW-1]) ? '0 : w_rnd;
        o_sat = 1'b0;
        o_q   = w_rl[OUT_WIDTH-1:0];
        if (w_rl > MAXV) begin
            o_q   = MAXV[OUT_WIDTH-1:0];
            o_sat = 1'b1;
        end else if (w_rl < MINV) begin
            o_q   = MINV[OUT_WIDTH-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/post_proc_unit.sv
// Post-processing stage: multi-pass accumulate, bias, requantise, emit one vector per group.
// Define PPU_STATS_EN to add output-handshake and saturation counters.
module post_proc_unit
    import ppu_pkg::*;
#(
    parameter int unsigned SA_ROWS   = 3,
    parameter int unsigned SA_COLS   = 1,
    parameter int unsigned C_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned OUT_WIDTH = PPU_OUT_WIDTH,
    parameter int unsigned PASS_W    = 8
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic                                            i_pre_valid,
    output logic                                            o_pre_ready,
    input  logic [SA_COLS-1:0][SA_ROWS-1:0][C_WIDTH-1:0]    i_c,
    input  logic [PASS_W-1:0]                               i_cfg_passes,
    input  logic [4:0]                                      i_cfg_shift,
    input  logic                                            i_cfg_relu,
    input  logic [SA_COLS-1:0][ACC_WIDTH-1:0]               i_bias,
    output logic                                            o_post_valid,
    input  logic                                            i_post_ready,
    output logic [SA_COLS-1:0][SA_ROWS-1:0][OUT_WIDTH-1:0]  o_q,
`ifdef PPU_STATS_EN
    output logic [31:0]                                     o_out_cnt,
    output logic [31:0]                                     o_sat_cnt,
`endif
    output logic                                            o_busy
);

    ppu_state_e                               r_state;
    logic [PASS_W-1:0]                        r_pass_cnt;
    logic [PASS_W-1:0]                        r_passes;
    logic [4:0]                               r_shift;
    logic                                     r_relu;
    logic [SA_COLS-1:0][ACC_WIDTH-1:0]        r_bias;
    logic signed [ACC_WIDTH-1:0]              r_acc [SA_COLS][SA_ROWS];
    logic [SA_COLS-1:0][SA_ROWS-1:0][OUT_WIDTH-1:0] r_q;
    logic [SA_COLS-1:0][SA_ROWS-1:0][OUT_WIDTH-1:0] w_q;
    logic [PASS_W-1:0]                        w_passes;
    logic                                     w_last;

    // The first accept of a group uses the live config, which is latched at the same edge.
    always_comb begin
        w_passes = (r_pass_cnt == '0) ? i_cfg_passes : r_passes;
        w_last   = (w_passes <= PASS_W'(1)) || (r_pass_cnt == w_passes - 1'b1);
    end

`ifdef PPU_STATS_EN
    logic [SA_COLS-1:0][SA_ROWS-1:0] w_sat;
    logic [31:0]                     w_sat_sum;
    logic [31:0]                     r_out_cnt;
    logic [31:0]                     r_sat_cnt;

    always_comb begin
        w_sat_sum = '0;
        for (int c = 0; c < int'(SA_COLS); c++) begin
            for (int r = 0; r < int'(SA_ROWS); r++) begin
                w_sat_sum = w_sat_sum + 32'(w_sat[c][r]);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_cnt <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (r_state == S_QUANT) r_sat_cnt <= r_sat_cnt + w_sat_sum;
            if (r_state == S_OUT && i_post_ready) r_out_cnt <= r_out_cnt + 32'd1;
        end
    end

    assign o_out_cnt = r_out_cnt;
    assign o_sat_cnt = r_sat_cnt;
`endif

    for (genvar c = 0; c < SA_COLS; c++) begin : g_col
        for (genvar r = 0; r < SA_ROWS; r++) begin : g_row
            ppu_requant #(
                .ACC_WIDTH (ACC_WIDTH),
                .OUT_WIDTH (OUT_WIDTH)
            ) u_requant (
                .i_acc   (r_acc[c][r]),
                .i_bias  (r_bias[c]),
                .i_shift (r_shift),
                .i_relu  (r_relu),
                .o_q     (w_q[c][r]),
`ifdef PPU_STATS_EN
                .o_sat   (w_sat[c][r])
`else
                .o_sat   ()
`endif
            );
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_ACC;
            r_pass_cnt <= '0;
            r_passes   <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_bias     <= '0;
            r_q        <= '0;
            for (int c = 0; c < int'(SA_COLS); c++) begin
                for (int r = 0; r < int'(SA_ROWS); r++) begin
                    r_acc[c][r] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_ACC: begin
                    if (i_pre_valid) begin
                        if (r_pass_cnt == '0) begin
                            r_passes <= i_cfg_passes;
                            r_shift  <= i_cfg_shift;
                            r_relu   <= i_cfg_relu;
                            r_bias   <= i_bias;
                        end
                        for (int c = 0; c < int'(SA_COLS); c++) begin
                            for (int r = 0; r < int'(SA_ROWS); r++) begin
                                r_acc[c][r] <= (r_pass_cnt == '0)
                                    ? ACC_WIDTH'($signed(i_c[c][r]))
                                    : ACC_WIDTH'(sat_add(64'(r_acc[c][r]),
                                                         64'($signed(i_c[c][r])), ACC_WIDTH));
                            end
                        end
                        if (w_last) begin
                            r_state    <= S_QUANT;
                            r_pass_cnt <= '0;
                        end else begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                        end
                    end
                end
                S_QUANT: begin
                    r_q     <= w_q;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (i_post_ready) r_state <= S_ACC;
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

    assign o_pre_ready  = (r_state == S_ACC);
    assign o_post_valid = (r_state == S_OUT);
    assign o_busy       = !((r_state == S_ACC) && (r_pass_cnt == '0));
    assign o_q          = r_q;

endmodule

// File: tb/tb_post_proc_unit.sv
// Directed self-checking bench for post_proc_unit (3 rows, 1 column, PASS_W=10).
module tb_post_proc_unit;

    localparam int unsigned SA_ROWS   = 3;
    localparam int unsigned SA_COLS   = 1;
    localparam int unsigned C_WIDTH   = 16;
    localparam int unsigned ACC_WIDTH = 24;
    localparam int unsigned OUT_WIDTH = 8;
    localparam int unsigned PASS_W    = 10;

    logic                                            i_clk;
    logic                                            i_rst;
    logic                                            i_pre_valid;
    logic                                            o_pre_ready;
    logic [SA_COLS-1:0][SA_ROWS-1:0][C_WIDTH-1:0]    i_c;
    logic [PASS_W-1:0]                               i_cfg_passes;
    logic [4:0]                                      i_cfg_shift;
    logic                                            i_cfg_relu;
    logic [SA_COLS-1:0][ACC_WIDTH-1:0]               i_bias;
    logic                                            o_post_valid;
    logic                                            i_post_ready;
    logic [SA_COLS-1:0][SA_ROWS-1:0][OUT_WIDTH-1:0]  o_q;
    logic                                            o_busy;
`ifdef PPU_STATS_EN
    logic [31:0]                                     o_out_cnt;
    logic [31:0]                                     o_sat_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    post_proc_unit #(
        .SA_ROWS   (SA_ROWS),
        .SA_COLS   (SA_COLS),
        .C_WIDTH   (C_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .PASS_W    (PASS_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_c          (i_c),
        .i_cfg_passes (i_cfg_passes),
        .i_cfg_shift  (i_cfg_shift),
        .i_cfg_relu   (i_cfg_relu),
        .i_bias       (i_bias),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_q          (o_q),
`ifdef PPU_STATS_EN
        .o_out_cnt    (o_out_cnt),
        .o_sat_cnt    (o_sat_cnt),
`endif
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_q(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_q0"}, $signed(o_q[0][0]), e0);
        check({tag, "_q1"}, $signed(o_q[0][1]), e1);
        check({tag, "_q2"}, $signed(o_q[0][2]), e2);
    endtask

    task automatic set_cfg(input int passes, input int shift, input int relu, input int bias);
        i_cfg_passes = PASS_W'(passes);
        i_cfg_shift  = 5'(shift);
        i_cfg_relu   = 1'(relu);
        i_bias[0]    = ACC_WIDTH'(bias);
    endtask

    task automatic send(input int a, input int b, input int c);
        int n;
        i_c[0][0]   = C_WIDTH'(a);
        i_c[0][1]   = C_WIDTH'(b);
        i_c[0][2]   = C_WIDTH'(c);
        i_pre_valid = 1'b1;
        n = 0;
        while (!o_pre_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_pre_ready) check("send_timeout", 0, 1);
        @(posedge i_clk); #1;
        i_pre_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!o_post_valid && cyc < 20) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        if (!o_post_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic take();
        i_post_ready = 1'b1;
        @(posedge i_clk); #1;
        i_post_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        i_rst        = 1'b1;
        i_pre_valid  = 1'b0;
        i_post_ready = 1'b0;
        i_c          = '0;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("rst_valid", o_post_valid, 0);
        check("rst_ready", o_pre_ready, 1);
        check("rst_busy", o_busy, 0);
        check_q("rst", 0, 0, 0);

        // 1: single pass passthrough, latency
        set_cfg(1, 0, 0, 0);
        send(5, -3, 127);
        check("t1_valid_quant", o_post_valid, 0);
        check("t1_ready_quant", o_pre_ready, 0);
        check("t1_busy", o_busy, 1);
        wait_valid(cyc);
        check("t1_latency", cyc, 1);
        check_q("t1", 5, -3, 127);
        take();
        check("t1_valid_drop", o_post_valid, 0);
        check("t1_ready_back", o_pre_ready, 1);

        // 2: three passes, bias and rounding shift; mid-group config ignored
        set_cfg(3, 2, 0, 4);
        send(10, 10, 10);
        set_cfg(1, 0, 1, -100);
        check("t2_busy_mid", o_busy, 1);
        send(10, 10, 10);
        check("t2_no_early_valid", o_post_valid, 0);
        send(10, 10, 10);
        wait_valid(cyc);
        check_q("t2", 9, 9, 9);
        take();
        repeat (3) @(posedge i_clk);
        #1;
        check("t2_single_output", o_post_valid, 0);

        // 3: ReLU and positive saturation
        set_cfg(1, 0, 1, 0);
        send(-50, 200, 0);
        wait_valid(cyc);
        check_q("t3", 0, 127, 0);
        take();
`ifdef PPU_STATS_EN
        check("t3_sat_cnt", o_sat_cnt, 1);
        check("t3_out_cnt", o_out_cnt, 3);
`endif

        // ready without valid does nothing
        i_post_ready = 1'b1;
        @(posedge i_clk); #1;
        i_post_ready = 1'b0;
        check("idle_ready_valid", o_post_valid, 0);
        check("idle_ready_busy", o_busy, 0);

        // 4: negative saturation, backpressure holds output, input ignored
        set_cfg(1, 0, 0, 0);
        send(-1000, -1000, -1000);
        wait_valid(cyc);
        i_c[0][0]   = C_WIDTH'(1);
        i_c[0][1]   = C_WIDTH'(1);
        i_c[0][2]   = C_WIDTH'(1);
        i_pre_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_q0", $signed(o_q[0][0]), -128);
            check("t4_hold_ready", o_pre_ready, 0);
            check("t4_hold_valid", o_post_valid, 1);
            @(posedge i_clk); #1;
        end
        i_pre_valid = 1'b0;
        check_q("t4", -128, -128, -128);
        take();
        check("t4_busy_after", o_busy, 0);
`ifdef PPU_STATS_EN
        check("t4_sat_cnt", o_sat_cnt, 4);
`endif

        // 5: accumulator clamps at 8388607; (8388607+32768)>>>16 = 128 -> 127
        set_cfg(600, 16, 0, 0);
        for (int k = 0; k < 600; k++) begin
            send(32767, 32767, 32767);
            if (k == 300) check("t5_busy_mid", o_busy, 1);
        end
        wait_valid(cyc);
        check_q("t5", 127, 127, 127);
        take();
`ifdef PPU_STATS_EN
        check("t5_sat_cnt", o_sat_cnt, 7);
`endif

        // 6: reset mid-group discards partial sums
        set_cfg(3, 0, 0, 0);
        send(1, 2, 3);
        send(1, 2, 3);
        i_rst = 1'b1;
        #1;
        check("t6_rst_valid", o_post_valid, 0);
        check("t6_rst_ready", o_pre_ready, 1);
        check("t6_rst_busy", o_busy, 0);
        check_q("t6_rst", 0, 0, 0);
`ifdef PPU_STATS_EN
        check("t6_rst_sat_cnt", o_sat_cnt, 0);
        check("t6_rst_out_cnt", o_out_cnt, 0);
`endif
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        send(1, 2, 3);
        send(1, 2, 3);
        send(1, 2, 3);
        wait_valid(cyc);
        check_q("t6", 3, 6, 9);
        take();
`ifdef PPU_STATS_EN
        check("t6_out_cnt", o_out_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
